regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 96 +++++++++
 tb/tb_regfile_sb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Two-write, multi-read register file with pending-write scoreboard.
// Read ports forward same-cycle writes when BYPASS is set.
module regfile_sb #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wen0,
    input  logic [ADDR_WIDTH-1:0]        waddr0,
    input  logic [DATA_WIDTH-1:0]        wdata0,
    input  logic                         wen1,
    input  logic [ADDR_WIDTH-1:0]        waddr1,
    input  logic [DATA_WIDTH-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]            rbusy,
    input  logic                         alloc_en,
    input  logic [ADDR_WIDTH-1:0]        alloc_addr,
    input  logic [ADDR_WIDTH-1:0]        dbg_addr,
    output logic [DATA_WIDTH-1:0]        dbg_data,
    output logic                         busy_any
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_nxt;
    logic                  we0;
    logic                  we1;
    logic                  ae;

    // Entry 0 is hardwired when ZERO_REG is set, so its traffic is dropped here.
    assign we0 = wen0 && !(ZERO_REG != 0 && waddr0 == '0);
    assign we1 = wen1 && !(ZERO_REG != 0 && waddr1 == '0);
    assign ae  = alloc_en && !(ZERO_REG != 0 && alloc_addr == '0);

    // Allocation is applied last so it wins over a same-cycle write.
    always_comb begin
        busy_nxt = busy;
        if (we0) busy_nxt[waddr0] = 1'b0;
        if (we1) busy_nxt[waddr1] = 1'b0;
        if (ae)  busy_nxt[alloc_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (we0) mem[waddr0] <= wdata0;
            if (we1) mem[waddr1] <= wdata1;
            busy <= busy_nxt;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] d;
        logic                  b;

        assign a = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            d = mem[a];
            b = busy[a];
            if (BYPASS != 0) begin
                if (we1 && waddr1 == a) begin
                    d = wdata1;
                    b = 1'b0;
                end else if (we0 && waddr0 == a) begin
                    d = wdata0;
                    b = 1'b0;
                end
            end
            if (rst || (ZERO_REG != 0 && a == '0)) begin
                d = '0;
                b = 1'b0;
            end
        end

        assign rdata[g*DATA_WIDTH +: DATA_WIDTH] = d;
        assign rbusy[g] = b;
    end

    assign dbg_data = (rst || (ZERO_REG != 0 && dbg_addr == '0))
                    ? '0 : mem[dbg_addr];
    assign busy_any = !rst && (|busy);

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus pushes expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen0, wen1, alloc_en;
    logic [4:0]  waddr0, waddr1, alloc_addr, dbg_addr;
    logic [31:0] wdata0, wdata1;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic [31:0] dbg_data;
    logic        busy_any;

    regfile_sb dut (
        .clk(clk), .rst(rst),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .busy_any(busy_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        int          port;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t        q[$];
    chk_t        c;
    logic [31:0] act;
    int          errors = 0;
    int          checks = 0;

    // Reference state: architectural contents and pending flags.
    logic [31:0] m_mem [32];
    logic [31:0] m_busy;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            c = q.pop_front();
            case (c.kind)
                0:       act = rdata[c.port*32 +: 32];
                1:       act = {31'd0, rbusy[c.port]};
                2:       act = dbg_data;
                default: act = {31'd0, busy_any};
            endcase
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
    end

    function automatic logic [4:0] ra(int p);
        logic [9:0] r;
        r = raddr;
        return (p == 0) ? r[4:0] : r[9:5];
    endfunction

    function automatic logic [31:0] exp_rd(logic [4:0] a);
        if (rst || a == 0) return 32'd0;
        if (wen1 && waddr1 == a) return wdata1;
        if (wen0 && waddr0 == a) return wdata0;
        return m_mem[a];
    endfunction

    function automatic logic [31:0] exp_rb(logic [4:0] a);
        if (rst || a == 0) return 32'd0;
        if ((wen1 && waddr1 == a) || (wen0 && waddr0 == a)) return 32'd0;
        return {31'd0, m_busy[a]};
    endfunction

    task automatic lit(int k, int p, logic [31:0] v, string n);
        chk_t e;
        e.kind = k;
        e.port = p;
        e.exp  = v;
        e.name = n;
        q.push_back(e);
    endtask

    task automatic idle();
        wen0 = 0; wen1 = 0; alloc_en = 0;
        waddr0 = 0; waddr1 = 0; alloc_addr = 0;
        wdata0 = 0; wdata1 = 0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
        m_busy = 32'd0;
    endtask

    // Push model expectations for this cycle, then advance one edge.
    task automatic step();
        lit(0, 0, exp_rd(ra(0)), "rdata0");
        lit(0, 1, exp_rd(ra(1)), "rdata1");
        lit(1, 0, exp_rb(ra(0)), "rbusy0");
        lit(1, 1, exp_rb(ra(1)), "rbusy1");
        lit(2, 0, (rst || dbg_addr == 0) ? 32'd0 : m_mem[dbg_addr], "dbg_data");
        lit(3, 0, {31'd0, !rst && (m_busy != 0)}, "busy_any");
        @(posedge clk);
        if (!rst) begin
            if (wen0 && waddr0 != 0) m_mem[waddr0] = wdata0;
            if (wen1 && waddr1 != 0) m_mem[waddr1] = wdata1;
            if (wen0) m_busy[waddr0] = 1'b0;
            if (wen1) m_busy[waddr1] = 1'b0;
            if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
        end
        #1;
    endtask

    initial begin
        clear_model();
        rst = 1;
        idle();
        raddr = 0;
        dbg_addr = 0;
        #1;
        // Activity during reset must stay invisible.
        wen0 = 1; waddr0 = 5; wdata0 = 32'hDEAD;
        alloc_en = 1; alloc_addr = 3;
        raddr = {5'd3, 5'd5}; dbg_addr = 5;
        lit(0, 0, 32'd0, "rst_rdata0");
        step();
        step();
        rst = 0;
        idle();

        wen0 = 1; waddr0 = 0; wdata0 = 32'hFFFF;
        alloc_en = 1; alloc_addr = 0;
        raddr = {5'd0, 5'd0}; dbg_addr = 0;
        step();
        idle();
        lit(0, 0, 32'd0, "zero_rdata");
        lit(2, 0, 32'd0, "zero_dbg");
        lit(1, 0, 32'd0, "zero_rbusy");
        lit(3, 0, 32'd0, "zero_busy_any");
        step();

        wen0 = 1; waddr0 = 5; wdata0 = 32'h1234;
        raddr = {5'd1, 5'd5};
        lit(0, 0, 32'h1234, "byp_w5");
        step();
        idle();
        lit(0, 0, 32'h1234, "rd_w5");
        step();

        wen0 = 1; waddr0 = 7; wdata0 = 32'hA;
        wen1 = 1; waddr1 = 7; wdata1 = 32'hB;
        raddr = {5'd7, 5'd7};
        lit(0, 1, 32'hB, "prio_byp");
        step();
        idle();
        dbg_addr = 7;
        lit(2, 0, 32'hB, "prio_store");
        step();

        alloc_en = 1; alloc_addr = 3;
        raddr = {5'd0, 5'd3};
        step();
        idle();
        lit(1, 0, 32'd1, "alloc_rbusy");
        lit(3, 0, 32'd1, "alloc_busy_any");
        step();
        wen0 = 1; waddr0 = 3; wdata0 = 32'h55;
        lit(1, 0, 32'd0, "wr3_rbusy");
        lit(0, 0, 32'h55, "wr3_rdata");
        step();
        idle();
        lit(3, 0, 32'd0, "wr3_busy_any");
        step();

        alloc_en = 1; alloc_addr = 9;
        wen0 = 1; waddr0 = 9; wdata0 = 32'h77;
        raddr = {5'd0, 5'd9};
        step();
        idle();
        dbg_addr = 9;
        lit(2, 0, 32'h77, "race_data");
        lit(1, 0, 32'd1, "race_busy");
        step();

        for (int a = 1; a < 32; a++) begin
            wen0 = 1; waddr0 = 5'(a); wdata0 = $urandom | 32'h1;
            alloc_en = 1; alloc_addr = 5'(a);
            step();
        end
        idle();
        lit(3, 0, 32'd1, "pop_busy_any");
        step();

        // Async pulse strictly between edges; checked at the next negedge.
        rst = 1;
        #2;
        rst = 0;
        clear_model();
        raddr = {5'd2, 5'd1};
        dbg_addr = 31;
        lit(3, 0, 32'd0, "arst_busy_any");
        lit(2, 0, 32'd0, "arst_dbg31");
        lit(0, 0, 32'd0, "arst_rdata1");
        step();
        for (int a = 1; a < 32; a++) begin
            dbg_addr = 5'(a);
            step();
        end

        for (int n = 0; n < 400; n++) begin
            wen0 = 1'($urandom);
            wen1 = 1'($urandom);
            alloc_en = 1'($urandom_range(0, 2) == 0);
            waddr0 = 5'($urandom_range(0, 7));
            waddr1 = 5'($urandom_range(0, 7));
            alloc_addr = 5'($urandom_range(0, 7));
            wdata0 = $urandom;
            wdata1 = $urandom;
            raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            dbg_addr = 5'($urandom_range(0, 31));
            step();
        end
        idle();
        step();

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
